pkt_filter_mc: RTL and testbench
================================

# pkt_filter_mc

Multi-port, back-pressured packet classifier at the RMT pipeline ingress. It buffers each packet's first beat and classifies the packet on its second beat. Packets go to one of two places: the data path (`m_axis_*`), or the control path (`ctrl_m_axis_*`) tagged with a control-channel index. Both outputs honour tready, non-qualifying traffic is dropped or forwarded according to a mode parameter, and per-class packet counters are exported for the control plane.

## Interface
- `C_S_AXIS_DATA_WIDTH`, 256: tdata width; must be ≥256 (header field offsets are fixed).
- `C_S_AXIS_TUSER_WIDTH`, 128: tuser width.
- `NUM_CTRL_PORTS`, 2: number of control UDP ports, 1..16.
- `CTRL_PORTS`, {16'hf2f2,16'hf2f1}: flattened 16*NUM_CTRL_PORTS list; entry i is `CTRL_PORTS[16*i+:16]` in wire byte order.
- `DROP_NON_UDP`, 1: 1 = drop non-IPv4/UDP packets; 0 = forward them to the data path.
- `FIFO_DEPTH_BITS`, 4: input FIFO depth is 2^FIFO_DEPTH_BITS beats.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `s_axis_tdata/tkeep/tuser/tvalid/tlast` in: ingress stream; `s_axis_tready` out 1.
- `m_axis_tdata/tkeep/tuser/tvalid/tlast` out: data-path stream; `m_axis_tready` in 1.
- `ctrl_m_axis_tdata/tkeep/tuser/tvalid/tlast` out: control stream; `ctrl_m_axis_tready` in 1.
- `ctrl_m_axis_tdest` out 4: index i of the matched CTRL_PORTS entry; held for the whole packet.
- `data_pkt_cnt`, `ctrl_pkt_cnt`, `drop_pkt_cnt` out 32 each: packet counters.

## Operation
- Ingress: beats are written to the fall-through FIFO when `s_axis_tvalid && s_axis_tready`. `s_axis_tready = ~nearly_full`; it is independent of the output readys.
- Qualifying header: first beat has `tdata[143:128]==16'h0008` and `tdata[223:216]==8'h11`. The UDP destination port is `tdata[79:64]` of the second beat.
- FSM states:
  - IDLE:
    - FIFO non-empty: pop the beat into the first-beat register.
    - Qualifying, not tlast → CLASSIFY.
    - Qualifying with tlast (single-beat UDP) → SEND_FIRST, dest = data.
    - Not qualifying, DROP_NON_UDP=1 → DROP, or back to IDLE if that beat has tlast.
    - Not qualifying, DROP_NON_UDP=0 → SEND_FIRST, dest = data.
  - CLASSIFY: once the FIFO is non-empty, peek (no pop) at the second beat. The lowest index i whose port matches selects control with `tdest=i`; no match selects data. → SEND_FIRST.
  - SEND_FIRST: load the first-beat register into the selected output register when it is free. → FLUSH, or → IDLE if the first beat had tlast.
  - FLUSH: pop FIFO beats into the selected output register whenever the FIFO is non-empty and that register is free. → IDLE after the tlast beat is loaded.
  - DROP: pop and discard FIFO beats. → IDLE after tlast.
- "Free" means the output's tvalid is 0, or its tvalid and tready are both 1 in the same cycle. Each output register holds tdata/tkeep/tuser/tlast/tdest stable while `tvalid && !tready`.
- Counters increment by 1 when a tlast beat completes:
  - `data_pkt_cnt`: handshake on m_axis.
  - `ctrl_pkt_cnt`: handshake on ctrl_m_axis.
  - `drop_pkt_cnt`: popped in DROP, or popped in IDLE when it was a dropped single-beat non-qualifying packet.
- Counters wrap from 0xFFFFFFFF to 0.
- Only one output carries a given packet, and a packet is never split across outputs.

## Timing
- Reset: state = IDLE, FIFO emptied, all tvalid/tlast/tdata/tkeep/tuser/tdest = 0, counters = 0, first-beat register = 0. A reset mid-packet discards the partial packet, and the next packet starts in IDLE.
- Minimum latency, beats back-to-back and outputs ready, with the first beat written at edge N:
  - pop at N+1;
  - classify at N+2;
  - first beat valid on the output after edge N+3;
  - subsequent beats at 1 beat/cycle.
- Output backpressure stalls the FSM only. The FIFO keeps accepting input until nearly_full (2^FIFO_DEPTH_BITS − 1 occupied), and `s_axis_tready` deasserts the cycle after.
- A stall on one output never corrupts the other output. The idle output keeps tvalid = 0.
- The FIFO write and read in the same cycle are both honoured.
- Counter increment and reset in the same cycle: reset wins.

## Test plan
- IPv4/UDP 3-beat packet, dport 16'hf2f1, both readys high → 3 beats on ctrl, tdest = 0, first beat 3 cycles after input, ctrl_pkt_cnt = 1, m_axis tvalid stays 0.
- IPv4/UDP 2-beat packet, dport 16'hf2f2, then a 4-beat packet with dport 16'h1234 → first on ctrl with tdest = 1; second on m_axis unchanged; counters ctrl = 1, data = 1.
- Non-IPv4 4-beat packet, DROP_NON_UDP = 1 → no output, drop_pkt_cnt = 1. Same stimulus with DROP_NON_UDP = 0 → 4 beats on m_axis.
- Data packet of 20 beats with m_axis_tready held 0 for 30 cycles → s_axis_tready falls after 15 beats occupy the FIFO; no beat lost or duplicated after release; output tdata stable during the stall.
- Single-beat IPv4/UDP packet (tlast on first beat) → forwarded on m_axis in one beat, data_pkt_cnt = 1.
- Assert reset during the FLUSH of a ctrl packet, then send a fresh data packet → all outputs and counters 0 during reset; the new packet is delivered intact on m_axis.

Source files
------------

// File: rtl/pkt_filter_mc_if.sv
// rtl/pkt_filter_mc_if.sv - stream bundle (tdata/tkeep/tuser/tvalid/tready/tlast/tdest) for pkt_filter_mc
interface pkt_filter_mc_if #(
    parameter int DATA_WIDTH = 256,
    parameter int USER_WIDTH = 128
) ();
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [USER_WIDTH-1:0]   tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic [3:0]              tdest;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, tdest, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, tdest, output tready);
endinterface

// File: rtl/pkt_filter_mc.sv
// rtl/pkt_filter_mc.sv - ingress packet classifier steering IPv4/UDP control ports to a control stream
module pkt_filter_mc #(
    parameter int                          C_S_AXIS_DATA_WIDTH  = 256,
    parameter int                          C_S_AXIS_TUSER_WIDTH = 128,
    parameter int                          NUM_CTRL_PORTS       = 2,
    parameter logic [16*NUM_CTRL_PORTS-1:0] CTRL_PORTS          = {16'hf2f2, 16'hf2f1},
    parameter bit                          DROP_NON_UDP         = 1'b1,
    parameter int                          FIFO_DEPTH_BITS      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    pkt_filter_mc_if.slave       s_axis,
    pkt_filter_mc_if.master      m_axis,
    pkt_filter_mc_if.master      ctrl_m_axis,
    output logic [31:0]          data_pkt_cnt,
    output logic [31:0]          ctrl_pkt_cnt,
    output logic [31:0]          drop_pkt_cnt
);
    localparam int DW    = C_S_AXIS_DATA_WIDTH;
    localparam int KW    = DW / 8;
    localparam int UW    = C_S_AXIS_TUSER_WIDTH;
    localparam int EW    = DW + KW + UW + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam logic [FIFO_DEPTH_BITS:0] NF_LEVEL = (FIFO_DEPTH_BITS + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLASSIFY, S_SEND_FIRST, S_FLUSH, S_DROP} state_t;

    // ---------------- input FIFO (fall-through) ----------------
    logic [EW-1:0]              r_mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] r_wptr;
    logic [FIFO_DEPTH_BITS-1:0] r_rptr;
    logic [FIFO_DEPTH_BITS:0]   r_count;
    logic                       w_wr;
    logic                       w_pop;
    logic                       w_empty;
    logic [EW-1:0]              w_head;
    logic [DW-1:0]              w_head_data;
    logic [KW-1:0]              w_head_keep;
    logic [UW-1:0]              w_head_user;
    logic                       w_head_last;

    assign w_empty          = (r_count == '0);
    assign s_axis.tready    = (r_count < NF_LEVEL);
    assign w_wr             = s_axis.tvalid & s_axis.tready;
    assign w_head           = r_mem[r_rptr];
    assign w_head_data      = w_head[DW-1:0];
    assign w_head_keep      = w_head[DW +: KW];
    assign w_head_user      = w_head[DW+KW +: UW];
    assign w_head_last      = w_head[EW-1];

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= {s_axis.tlast, s_axis.tuser, s_axis.tkeep, s_axis.tdata};
        end
    end

    // FIFO pointers and occupancy; simultaneous write and read both take effect
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- header decode on the FIFO head ----------------
    logic       w_qual;
    logic       w_match;
    logic [3:0] w_match_idx;

    assign w_qual = (w_head_data[143:128] == 16'h0008) && (w_head_data[223:216] == 8'h11);

    // lowest matching control port wins, so scan from the top down
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = 4'd0;
        for (int i = NUM_CTRL_PORTS - 1; i >= 0; i--) begin
            if (w_head_data[79:64] == CTRL_PORTS[16*i +: 16]) begin
                w_match     = 1'b1;
                w_match_idx = 4'(i);
            end
        end
    end

    // ---------------- FSM ----------------
    state_t r_state;
    state_t w_state_nxt;
    logic   r_sel_ctrl;
    logic [3:0] r_sel_dest;
    logic   r_m_tvalid;
    logic   r_c_tvalid;
    logic   w_sel_free;
    logic   w_load;
    logic   w_drop_pkt;
    logic [DW-1:0] r_first_data;
    logic [KW-1:0] r_first_keep;
    logic [UW-1:0] r_first_user;
    logic          r_first_last;

    assign w_sel_free = r_sel_ctrl ? (~r_c_tvalid | ctrl_m_axis.tready)
                                   : (~r_m_tvalid | m_axis.tready);

    // state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (w_qual)              w_state_nxt = w_head_last ? S_SEND_FIRST : S_CLASSIFY;
                    else if (!DROP_NON_UDP)  w_state_nxt = S_SEND_FIRST;
                    else                     w_state_nxt = w_head_last ? S_IDLE : S_DROP;
                end
            end
            S_CLASSIFY:   if (!w_empty) w_state_nxt = S_SEND_FIRST;
            S_SEND_FIRST: if (w_sel_free) w_state_nxt = r_first_last ? S_IDLE : S_FLUSH;
            S_FLUSH:      if (!w_empty && w_sel_free && w_head_last) w_state_nxt = S_IDLE;
            S_DROP:       if (!w_empty && w_head_last) w_state_nxt = S_IDLE;
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: FIFO pop, output-register load, drop event
    always_comb begin
        w_pop      = 1'b0;
        w_load     = 1'b0;
        w_drop_pkt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pop      = !w_empty;
                w_drop_pkt = !w_empty && !w_qual && DROP_NON_UDP && w_head_last;
            end
            S_SEND_FIRST: w_load = w_sel_free;
            S_FLUSH: begin
                w_load = !w_empty && w_sel_free;
                w_pop  = !w_empty && w_sel_free;
            end
            S_DROP: begin
                w_pop      = !w_empty;
                w_drop_pkt = !w_empty && w_head_last;
            end
            default: ;
        endcase
    end

    // first-beat holding register and destination selection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_first_data <= '0;
            r_first_keep <= '0;
            r_first_user <= '0;
            r_first_last <= 1'b0;
            r_sel_ctrl   <= 1'b0;
            r_sel_dest   <= 4'd0;
        end else if (r_state == S_IDLE && !w_empty) begin
            r_first_data <= w_head_data;
            r_first_keep <= w_head_keep;
            r_first_user <= w_head_user;
            r_first_last <= w_head_last;
            r_sel_ctrl   <= 1'b0;
            r_sel_dest   <= 4'd0;
        end else if (r_state == S_CLASSIFY && !w_empty) begin
            r_sel_ctrl   <= w_match;
            r_sel_dest   <= w_match ? w_match_idx : 4'd0;
        end
    end

    // ---------------- output registers ----------------
    logic [DW-1:0] w_ld_data;
    logic [KW-1:0] w_ld_keep;
    logic [UW-1:0] w_ld_user;
    logic          w_ld_last;
    logic          w_ld_m;
    logic          w_ld_c;

    assign w_ld_data = (r_state == S_SEND_FIRST) ? r_first_data : w_head_data;
    assign w_ld_keep = (r_state == S_SEND_FIRST) ? r_first_keep : w_head_keep;
    assign w_ld_user = (r_state == S_SEND_FIRST) ? r_first_user : w_head_user;
    assign w_ld_last = (r_state == S_SEND_FIRST) ? r_first_last : w_head_last;
    assign w_ld_m    = w_load & ~r_sel_ctrl;
    assign w_ld_c    = w_load &  r_sel_ctrl;

    logic [DW-1:0] r_m_tdata, r_c_tdata;
    logic [KW-1:0] r_m_tkeep, r_c_tkeep;
    logic [UW-1:0] r_m_tuser, r_c_tuser;
    logic          r_m_tlast, r_c_tlast;
    logic [3:0]    r_c_tdest;

    // data-path output register; payload held while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tuser  <= '0;
            r_m_tlast  <= 1'b0;
        end else if (w_ld_m) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_ld_data;
            r_m_tkeep  <= w_ld_keep;
            r_m_tuser  <= w_ld_user;
            r_m_tlast  <= w_ld_last;
        end else if (m_axis.tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    // control-path output register; tdest fixed for the whole packet
    always_ff @(posedge clk) begin
        if (reset) begin
            r_c_tvalid <= 1'b0;
            r_c_tdata  <= '0;
            r_c_tkeep  <= '0;
            r_c_tuser  <= '0;
            r_c_tlast  <= 1'b0;
            r_c_tdest  <= 4'd0;
        end else if (w_ld_c) begin
            r_c_tvalid <= 1'b1;
            r_c_tdata  <= w_ld_data;
            r_c_tkeep  <= w_ld_keep;
            r_c_tuser  <= w_ld_user;
            r_c_tlast  <= w_ld_last;
            r_c_tdest  <= r_sel_dest;
        end else if (ctrl_m_axis.tready) begin
            r_c_tvalid <= 1'b0;
        end
    end

    assign m_axis.tvalid      = r_m_tvalid;
    assign m_axis.tdata       = r_m_tdata;
    assign m_axis.tkeep       = r_m_tkeep;
    assign m_axis.tuser       = r_m_tuser;
    assign m_axis.tlast       = r_m_tlast;
    assign m_axis.tdest       = 4'd0;
    assign ctrl_m_axis.tvalid = r_c_tvalid;
    assign ctrl_m_axis.tdata  = r_c_tdata;
    assign ctrl_m_axis.tkeep  = r_c_tkeep;
    assign ctrl_m_axis.tuser  = r_c_tuser;
    assign ctrl_m_axis.tlast  = r_c_tlast;
    assign ctrl_m_axis.tdest  = r_c_tdest;

    // per-class packet counters, wrapping naturally at 32 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            data_pkt_cnt <= '0;
            ctrl_pkt_cnt <= '0;
            drop_pkt_cnt <= '0;
        end else begin
            if (r_m_tvalid && m_axis.tready && r_m_tlast)      data_pkt_cnt <= data_pkt_cnt + 32'd1;
            if (r_c_tvalid && ctrl_m_axis.tready && r_c_tlast) ctrl_pkt_cnt <= ctrl_pkt_cnt + 32'd1;
            if (w_drop_pkt)                                    drop_pkt_cnt <= drop_pkt_cnt + 32'd1;
        end
    end

    logic w_unused;
    assign w_unused = ^s_axis.tdest;
endmodule

// File: tb/tb_pkt_filter_mc.sv
// tb/tb_pkt_filter_mc.sv - directed self-checking bench for pkt_filter_mc
module tb_pkt_filter_mc;
    localparam int DW = 256;
    localparam int UW = 128;

    logic clk = 1'b0;
    logic reset;
    logic en1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pkt_filter_mc_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) s0 ();
    pkt_filter_mc_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) m0 ();
    pkt_filter_mc_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) c0 ();
    pkt_filter_mc_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) s1 ();
    pkt_filter_mc_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) m1 ();
    pkt_filter_mc_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) c1 ();

    logic [31:0] d0_data, d0_ctrl, d0_drop;
    logic [31:0] d1_data, d1_ctrl, d1_drop;

    assign s1.tdata  = s0.tdata;
    assign s1.tkeep  = s0.tkeep;
    assign s1.tuser  = s0.tuser;
    assign s1.tlast  = s0.tlast;
    assign s1.tdest  = 4'd0;
    assign s1.tvalid = s0.tvalid & en1;
    assign m1.tready = 1'b1;
    assign c1.tready = 1'b1;

    pkt_filter_mc #(.DROP_NON_UDP(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .s_axis(s0), .m_axis(m0), .ctrl_m_axis(c0),
        .data_pkt_cnt(d0_data), .ctrl_pkt_cnt(d0_ctrl), .drop_pkt_cnt(d0_drop));

    pkt_filter_mc #(.DROP_NON_UDP(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .s_axis(s1), .m_axis(m1), .ctrl_m_axis(c1),
        .data_pkt_cnt(d1_data), .ctrl_pkt_cnt(d1_ctrl), .drop_pkt_cnt(d1_drop));

    logic [DW-1:0] q_m0[$];
    logic          q_m0_last[$];
    logic [DW-1:0] q_c0[$];
    logic [3:0]    q_c0_dest[$];
    logic          q_c0_last[$];
    int            q_c0_cyc[$];
    logic [DW-1:0] q_m1[$];
    int            q_in_cyc[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (s0.tvalid && s0.tready) q_in_cyc.push_back(cyc + 1);
            if (m0.tvalid && m0.tready) begin
                q_m0.push_back(m0.tdata);
                q_m0_last.push_back(m0.tlast);
            end
            if (c0.tvalid && c0.tready) begin
                q_c0.push_back(c0.tdata);
                q_c0_dest.push_back(c0.tdest);
                q_c0_last.push_back(c0.tlast);
                q_c0_cyc.push_back(cyc);
            end
            if (m1.tvalid && m1.tready) q_m1.push_back(m1.tdata);
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat(input logic [7:0] id, input int idx,
                                           input logic udp, input logic [15:0] dport);
        logic [DW-1:0] d;
        d = '0;
        d[15:0]    = {id, 8'(idx)};
        d[255:240] = {id, 8'(idx)} ^ 16'h5a5a;
        if (idx == 0) begin
            d[143:128] = udp ? 16'h0008 : 16'hdd86;
            d[223:216] = udp ? 8'h11 : 8'h06;
        end
        if (idx == 1) d[79:64] = dport;
        return d;
    endfunction

    task automatic drive_beat(input logic [DW-1:0] data, input logic last, input logic [7:0] id);
        logic ok;
        int   t;
        s0.tdata  = data;
        s0.tkeep  = '1;
        s0.tuser  = {120'd0, id};
        s0.tlast  = last;
        s0.tvalid = 1'b1;
        ok = 1'b0;
        t  = 0;
        while (!ok && t < 500) begin
            @(negedge clk);
            ok = s0.tready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!ok) check("accept_timeout", 256'(ok), 256'(1));
    endtask

    task automatic send_pkt(input logic [7:0] id, input int n, input logic udp, input logic [15:0] dport);
        for (int i = 0; i < n; i++) drive_beat(beat(id, i, udp, dport), (i == n - 1), id);
        s0.tvalid = 1'b0;
        s0.tlast  = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int bm, bc, bi, b1;

    initial begin
        reset = 1'b1;
        en1   = 1'b0;
        s0.tvalid = 1'b0; s0.tlast = 1'b0; s0.tdata = '0; s0.tkeep = '0; s0.tuser = '0; s0.tdest = 4'd0;
        m0.tready = 1'b1;
        c0.tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_tvalid", 256'(m0.tvalid), 256'(0));
        check("rst_c_tvalid", 256'(c0.tvalid), 256'(0));
        check("rst_c_tdest",  256'(c0.tdest),  256'(0));
        check("rst_m_tdata",  m0.tdata, '0);
        check("rst_cnts",     256'({d0_data, d0_ctrl, d0_drop}), 256'(0));
        check("rst_s_tready", 256'(s0.tready), 256'(1));
        @(posedge clk); #1;
        reset = 1'b0;

        // 3-beat control packet on port f2f1
        bc = q_c0.size(); bm = q_m0.size(); bi = q_in_cyc.size();
        send_pkt(8'h01, 3, 1'b1, 16'hf2f1);
        tick(20);
        check("t1_c_beats", 256'(q_c0.size() - bc), 256'(3));
        for (int i = 0; i < 3; i++) begin
            check("t1_c_data", q_c0[bc+i], beat(8'h01, i, 1'b1, 16'hf2f1));
            check("t1_c_dest", 256'(q_c0_dest[bc+i]), 256'(0));
            check("t1_c_last", 256'(q_c0_last[bc+i]), 256'(i == 2));
        end
        check("t1_latency", 256'(q_c0_cyc[bc] - q_in_cyc[bi]), 256'(3));
        check("t1_m_beats", 256'(q_m0.size() - bm), 256'(0));
        check("t1_ctrl_cnt", 256'(d0_ctrl), 256'(1));
        check("t1_data_cnt", 256'(d0_data), 256'(0));

        // 2-beat control on f2f2, then 4-beat data on 1234
        bc = q_c0.size(); bm = q_m0.size();
        send_pkt(8'h02, 2, 1'b1, 16'hf2f2);
        send_pkt(8'h03, 4, 1'b1, 16'h1234);
        tick(30);
        check("t2_c_beats", 256'(q_c0.size() - bc), 256'(2));
        for (int i = 0; i < 2; i++) begin
            check("t2_c_data", q_c0[bc+i], beat(8'h02, i, 1'b1, 16'hf2f2));
            check("t2_c_dest", 256'(q_c0_dest[bc+i]), 256'(1));
        end
        check("t2_m_beats", 256'(q_m0.size() - bm), 256'(4));
        for (int i = 0; i < 4; i++) begin
            check("t2_m_data", q_m0[bm+i], beat(8'h03, i, 1'b1, 16'h1234));
            check("t2_m_last", 256'(q_m0_last[bm+i]), 256'(i == 3));
        end
        check("t2_ctrl_cnt", 256'(d0_ctrl), 256'(2));
        check("t2_data_cnt", 256'(d0_data), 256'(1));

        // non-IPv4 4-beat: dropped by dut0, forwarded by dut1
        bc = q_c0.size(); bm = q_m0.size(); b1 = q_m1.size();
        en1 = 1'b1;
        send_pkt(8'h04, 4, 1'b0, 16'hf2f1);
        en1 = 1'b0;
        tick(30);
        check("t3_drop_cnt", 256'(d0_drop), 256'(1));
        check("t3_m_beats",  256'(q_m0.size() - bm), 256'(0));
        check("t3_c_beats",  256'(q_c0.size() - bc), 256'(0));
        check("t3_fwd_beats", 256'(q_m1.size() - b1), 256'(4));
        for (int i = 0; i < 4; i++) check("t3_fwd_data", q_m1[b1+i], beat(8'h04, i, 1'b0, 16'hf2f1));
        check("t3_fwd_data_cnt", 256'(d1_data), 256'(1));
        check("t3_fwd_drop_cnt", 256'(d1_drop), 256'(0));

        // 20-beat data packet with m_axis stalled for 30 cycles
        bm = q_m0.size(); bi = q_in_cyc.size();
        m0.tready = 1'b0;
        fork
            send_pkt(8'h05, 20, 1'b1, 16'h0400);
            begin
                tick(10);
                @(negedge clk);
                check("t4_stall_valid", 256'(m0.tvalid), 256'(1));
                check("t4_stall_data_a", m0.tdata, beat(8'h05, 0, 1'b1, 16'h0400));
                @(posedge clk); #1;
                tick(19);
                @(negedge clk);
                check("t4_s_tready_low", 256'(s0.tready), 256'(0));
                check("t4_accepted", 256'(q_in_cyc.size() - bi), 256'(16));
                check("t4_stall_data_b", m0.tdata, beat(8'h05, 0, 1'b1, 16'h0400));
                @(posedge clk); #1;
                m0.tready = 1'b1;
            end
        join
        tick(40);
        check("t4_m_beats", 256'(q_m0.size() - bm), 256'(20));
        for (int i = 0; i < 20; i++) check("t4_m_data", q_m0[bm+i], beat(8'h05, i, 1'b1, 16'h0400));
        check("t4_data_cnt", 256'(d0_data), 256'(2));

        // single-beat IPv4/UDP goes to the data path
        bm = q_m0.size(); bc = q_c0.size();
        send_pkt(8'h06, 1, 1'b1, 16'hf2f1);
        tick(20);
        check("t5_m_beats", 256'(q_m0.size() - bm), 256'(1));
        check("t5_m_data",  q_m0[bm], beat(8'h06, 0, 1'b1, 16'hf2f1));
        check("t5_m_last",  256'(q_m0_last[bm]), 256'(1));
        check("t5_c_beats", 256'(q_c0.size() - bc), 256'(0));
        check("t5_data_cnt", 256'(d0_data), 256'(3));

        // reset in the middle of a stalled control packet, then a fresh data packet
        c0.tready = 1'b0;
        for (int i = 0; i < 3; i++) drive_beat(beat(8'h07, i, 1'b1, 16'hf2f1), 1'b0, 8'h07);
        s0.tvalid = 1'b0;
        tick(6);
        check("t6_pre_c_valid", 256'(c0.tvalid), 256'(1));
        reset = 1'b1;
        tick(2);
        @(negedge clk);
        check("t6_rst_c_valid", 256'(c0.tvalid), 256'(0));
        check("t6_rst_c_data",  c0.tdata, '0);
        check("t6_rst_c_last",  256'(c0.tlast), 256'(0));
        check("t6_rst_m_valid", 256'(m0.tvalid), 256'(0));
        check("t6_rst_cnts",    256'({d0_data, d0_ctrl, d0_drop}), 256'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        c0.tready = 1'b1;
        bm = q_m0.size(); bc = q_c0.size();
        send_pkt(8'h08, 3, 1'b1, 16'h0777);
        tick(30);
        check("t6_m_beats", 256'(q_m0.size() - bm), 256'(3));
        for (int i = 0; i < 3; i++) check("t6_m_data", q_m0[bm+i], beat(8'h08, i, 1'b1, 16'h0777));
        check("t6_c_beats", 256'(q_c0.size() - bc), 256'(0));
        check("t6_data_cnt", 256'(d0_data), 256'(1));
        check("t6_ctrl_cnt", 256'(d0_ctrl), 256'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
